// File: rtl/uart_status_reporter.sv
// Serialises a status snapshot (score, mistakes, FSM state) into a short ASCII
// line, handing one byte at a time to a ready/send UART transmitter.
module uart_status_reporter #(
  parameter bit CRLF_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       report_req,
  input  logic [7:0] score,
  input  logic [1:0] mistakes,
  input  logic [4:0] state,
  input  logic       uart_tx_ready,
  output logic       uart_tx_send,
  output logic [7:0] uart_tx_byte,
  output logic       busy,
  output logic       report_done
);

  localparam logic [3:0] LAST_IDX = CRLF_EN ? 4'd11 : 4'd9;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_LOW, FINISH} state_t;

  state_t     r_state;
  logic [7:0] r_score;
  logic [1:0] r_mistakes;
  logic [4:0] r_code;
  logic [3:0] r_idx;
  logic       r_pending;
  logic       r_busy;
  logic [7:0] r_last_byte;
  logic [7:0] w_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  // Byte selected by the current report index, built from the snapshot only
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = 8'h53;
      4'd1:    w_byte = hex_ascii(r_score[7:4]);
      4'd2:    w_byte = hex_ascii(r_score[3:0]);
      4'd3:    w_byte = 8'h20;
      4'd4:    w_byte = 8'h4D;
      4'd5:    w_byte = 8'h30 + 8'(r_mistakes);
      4'd6:    w_byte = 8'h20;
      4'd7:    w_byte = 8'h54;
      4'd8:    w_byte = hex_ascii({3'b000, r_code[4]});
      4'd9:    w_byte = hex_ascii(r_code[3:0]);
      4'd10:   w_byte = 8'h0D;
      4'd11:   w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  // Strobe and done fire in the same cycle the transmitter reports ready
  assign uart_tx_send = (r_state == SEND) && uart_tx_ready;
  assign uart_tx_byte = uart_tx_send ? w_byte : r_last_byte;
  assign report_done  = (r_state == FINISH) && uart_tx_ready;
  assign busy         = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_score     <= '0;
      r_mistakes  <= '0;
      r_code      <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_last_byte <= '0;
    end else begin
      if (report_req && (r_state != IDLE)) r_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (report_req) begin
            r_score    <= score;
            r_mistakes <= mistakes;
            r_code     <= state;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_idx   <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (uart_tx_ready) begin
            r_last_byte <= w_byte;
            r_state     <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!uart_tx_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= FINISH;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= SEND;
            end
          end
        end
        FINISH: begin
          // A queued or coincident request chains straight into a new report
          if (uart_tx_ready) begin
            if (r_pending || report_req) begin
              r_score    <= score;
              r_mistakes <= mistakes;
              r_code     <= state;
              r_pending  <= 1'b0;
              r_state    <= LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_reporter.sv
// Directed bench for uart_status_reporter: one CRLF instance and one without,
// each driven by a transmitter model that drops ready for 20 cycles per byte.
module tb_uart_status_reporter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] score = 8'h00;
  logic [1:0] mistakes = 2'd0;
  logic [4:0] st = 5'd0;
  logic       ready_a, ready_b;
  logic       tx_auto = 1'b1;
  logic       man_ready = 1'b0;
  logic       send_a, send_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] byte_a, byte_b;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int done_cnt = 0;
  int done_b_cnt = 0;
  int dbl = 0;
  logic prev_send = 1'b0;
  logic [7:0] sq[$];
  logic [7:0] bq[$];
  int scyc[$];
  int dcyc[$];

  logic [7:0] exp_a [12] = '{8'h53, 8'h32, 8'h41, 8'h20, 8'h4D, 8'h32,
                             8'h20, 8'h54, 8'h31, 8'h33, 8'h0D, 8'h0A};
  logic [7:0] exp_b [10] = '{8'h53, 8'h30, 8'h39, 8'h20, 8'h4D, 8'h30,
                             8'h20, 8'h54, 8'h30, 8'h30};

  uart_status_reporter #(.CRLF_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .report_req(req), .score(score),
    .mistakes(mistakes), .state(st), .uart_tx_ready(ready_a),
    .uart_tx_send(send_a), .uart_tx_byte(byte_a), .busy(busy_a),
    .report_done(done_a));

  uart_status_reporter #(.CRLF_EN(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .report_req(req_b), .score(score),
    .mistakes(mistakes), .state(st), .uart_tx_ready(ready_b),
    .uart_tx_send(send_b), .uart_tx_byte(byte_b), .busy(busy_b),
    .report_done(done_b));

  always #5 clk = ~clk;

  assign ready_a = tx_auto ? (cnt_a == 0) : man_ready;
  assign ready_b = (cnt_b == 0);

  // Transmitter models and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (send_a) cnt_a <= 20;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (send_b) cnt_b <= 20;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  end

  // Mid-cycle recorder of strobes and done pulses
  always @(negedge clk) begin
    if (send_a) begin
      sq.push_back(byte_a);
      scyc.push_back(cyc);
    end
    if (send_a && prev_send) dbl++;
    prev_send = send_a;
    if (done_a) begin
      done_cnt++;
      dcyc.push_back(cyc);
    end
    if (send_b) bq.push_back(byte_b);
    if (done_b) done_b_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int k = 0;
    while (sq.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(sq.size() >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int base, d0, c0, k;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_send", 32'(send_a), 32'd0);
    chk("rst_byte", 32'(byte_a), 32'h00);
    chk("rst_done", 32'(done_a), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Basic report with latency and snapshot isolation
    score = 8'h2A; mistakes = 2'd2; st = 5'h13;
    base = sq.size(); d0 = done_cnt; c0 = cyc;
    pulse_req();
    chk("busy_rise", 32'(busy_a), 32'd1);
    wait_sends(base + 1, 10, "first_send_to");
    chk("latency", 32'(scyc[base]), 32'(c0 + 2));
    wait_sends(base + 2, 60, "second_send_to");
    score = 8'hFF;
    wait_dones(d0 + 1, 600, "basic_done_to");
    chk("basic_len", 32'(sq.size() - base), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("basic_b%0d", i), 32'(sq[base + i]), 32'(exp_a[i]));
    chk("busy_fall", 32'(busy_a), 32'd0);
    repeat (20) tick();
    chk("basic_one_done", 32'(done_cnt - d0), 32'd1);

    // Second report picks up the new score
    base = sq.size(); d0 = done_cnt;
    pulse_req();
    wait_dones(d0 + 1, 600, "snap2_done_to");
    chk("snap2_hi", 32'(sq[base + 1]), 32'h46);
    chk("snap2_lo", 32'(sq[base + 2]), 32'h46);
    repeat (25) tick();

    // Ten-byte report without CRLF on the second instance
    score = 8'h09; mistakes = 2'd0; st = 5'h00;
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    k = 0;
    while (done_b_cnt < 1 && k < 600) begin
      tick();
      k++;
    end
    repeat (50) tick();
    chk("b_done", 32'(done_b_cnt), 32'd1);
    chk("b_len", 32'(bq.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("b_b%0d", i), 32'(bq[i]), 32'(exp_b[i]));

    // Three requests during a report yield exactly one follow-up
    score = 8'h2A; mistakes = 2'd2; st = 5'h13;
    base = sq.size(); d0 = done_cnt;
    pulse_req();
    wait_sends(base + 1, 10, "multi_s1_to");
    pulse_req();
    wait_sends(base + 4, 100, "multi_s4_to");
    pulse_req();
    wait_sends(base + 8, 100, "multi_s8_to");
    pulse_req();
    wait_dones(d0 + 2, 1200, "multi_done_to");
    repeat (300) tick();
    chk("multi_dones", 32'(done_cnt - d0), 32'd2);
    chk("multi_sends", 32'(sq.size() - base), 32'd24);
    chk("multi_gap", 32'(scyc[base + 12] - dcyc[d0]), 32'd2);

    // Backpressure: ready held low well past LOAD
    man_ready = 1'b0;
    tx_auto = 1'b0;
    tick();
    base = sq.size(); d0 = done_cnt;
    pulse_req();
    repeat (100) tick();
    chk("bp_no_send", 32'(sq.size() - base), 32'd0);
    chk("bp_busy", 32'(busy_a), 32'd1);
    chk("bp_hold_byte", 32'(byte_a), 32'h0A);
    man_ready = 1'b1;
    @(negedge clk);
    chk("bp_send", 32'(send_a), 32'd1);
    chk("bp_byte", 32'(byte_a), 32'h53);
    tick();
    tx_auto = 1'b1;
    wait_dones(d0 + 1, 600, "bp_done_to");
    repeat (25) tick();

    // Reset mid-report abandons it
    base = sq.size(); d0 = done_cnt;
    pulse_req();
    wait_sends(base + 5, 200, "rr_s5_to");
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rr_busy", 32'(busy_a), 32'd0);
    chk("rr_send", 32'(send_a), 32'd0);
    chk("rr_byte", 32'(byte_a), 32'h00);
    chk("rr_done", 32'(done_a), 32'd0);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    reset = 1'b0;
    tick();
    chk("rr_req_ignored", 32'(busy_a), 32'd0);
    repeat (60) tick();
    chk("rr_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rr_no_more", 32'(sq.size() - base), 32'd5);
    base = sq.size();
    pulse_req();
    wait_sends(base + 1, 30, "rr_restart_to");
    chk("rr_restart_S", 32'(sq[base]), 32'h53);
    wait_dones(d0 + 1, 600, "rr_done_to");
    chk("rr_restart_len", 32'(sq.size() - base), 32'd12);

    chk("no_back_to_back", 32'(dbl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
